// File: rtl/count_seq_if.sv
// Configuration channel of count_seq: bounds and bounce limit offered with a
// valid/ready handshake, plus the one-cycle rejection pulse.
interface count_seq_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_lo;
    logic [3:0] cfg_hi;
    logic [3:0] cfg_bounces;
    logic       cfg_err;

    modport master (
        output cfg_valid,
        output cfg_lo,
        output cfg_hi,
        output cfg_bounces,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_lo,
        input  cfg_hi,
        input  cfg_bounces,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/count_seq.sv
// Bouncing up/down counter between configurable bounds with run/pause/step
// control and an optional number of direction reversals before completion.
module count_seq (
    input  logic        clk,
    input  logic        reset,
    count_seq_if.slave  cfg,
    input  logic        start,
    input  logic        pause,
    input  logic        step,
    input  logic        stop,
    output logic [3:0]  out,
    output logic        dir,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t     state_reg;
    logic [3:0] out_reg;
    logic       dir_reg;
    logic [3:0] rev_reg;
    logic [3:0] lo_reg;
    logic [3:0] hi_reg;
    logic [3:0] limit_reg;
    logic       done_reg;
    logic       cfg_err_reg;
    logic       busy_reg;

    logic       cfg_ok;
    logic       cfg_take;
    logic [3:0] start_lo;
    logic [3:0] rev_inc;
    logic [3:0] adv_out;
    logic       adv_dir;
    logic [3:0] adv_rev;
    logic       adv_end;

    assign cfg_ok   = cfg.cfg_lo < cfg.cfg_hi;
    assign cfg_take = cfg.cfg_valid && (state_reg == IDLE) && cfg_ok;
    // A start in the same cycle as an accepted transfer begins at the new lower bound.
    assign start_lo = cfg_take ? cfg.cfg_lo : lo_reg;
    assign rev_inc  = rev_reg + 4'd1;

    // One advance of the sweep; at a bound the reversal may end the sweep instead.
    always_comb begin
        adv_out = out_reg;
        adv_dir = dir_reg;
        adv_rev = rev_reg;
        adv_end = 1'b0;
        if (!dir_reg) begin
            if (out_reg < hi_reg) begin
                adv_out = out_reg + 4'd1;
            end else begin
                adv_rev = rev_inc;
                adv_dir = 1'b1;
                if ((limit_reg != 4'd0) && (rev_inc == limit_reg)) begin
                    adv_end = 1'b1;
                end else begin
                    adv_out = out_reg - 4'd1;
                end
            end
        end else begin
            if (out_reg > lo_reg) begin
                adv_out = out_reg - 4'd1;
            end else begin
                adv_rev = rev_inc;
                adv_dir = 1'b0;
                if ((limit_reg != 4'd0) && (rev_inc == limit_reg)) begin
                    adv_end = 1'b1;
                end else begin
                    adv_out = out_reg + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            out_reg     <= 4'd0;
            dir_reg     <= 1'b0;
            rev_reg     <= 4'd0;
            lo_reg      <= 4'd0;
            hi_reg      <= 4'd15;
            limit_reg   <= 4'd0;
            done_reg    <= 1'b0;
            cfg_err_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            cfg_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cfg.cfg_valid) begin
                        if (cfg_ok) begin
                            lo_reg    <= cfg.cfg_lo;
                            hi_reg    <= cfg.cfg_hi;
                            limit_reg <= cfg.cfg_bounces;
                        end else begin
                            cfg_err_reg <= 1'b1;
                        end
                    end
                    if (start) begin
                        out_reg   <= start_lo;
                        dir_reg   <= 1'b0;
                        rev_reg   <= 4'd0;
                        state_reg <= RUN;
                        busy_reg  <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (pause) begin
                        state_reg <= PAUSE;
                    end else begin
                        out_reg <= adv_out;
                        dir_reg <= adv_dir;
                        rev_reg <= adv_rev;
                        if (adv_end) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (start) begin
                        state_reg <= RUN;
                    end else if (step) begin
                        out_reg <= adv_out;
                        dir_reg <= adv_dir;
                        rev_reg <= adv_rev;
                        if (adv_end) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg.cfg_ready = (state_reg == IDLE);
    assign cfg.cfg_err   = cfg_err_reg;
    assign out           = out_reg;
    assign dir           = dir_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
endmodule

// File: tb/tb_count_seq.sv
// Scoreboard bench for count_seq: expected per-cycle outputs are queued as
// stimulus is applied and compared one entry per clock.
module tb_count_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       step = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] out;
    logic       dir;
    logic       busy;
    logic       done;

    count_seq_if cfg_bus ();

    count_seq dut (
        .clk   (clk),
        .reset (reset),
        .cfg   (cfg_bus.slave),
        .start (start),
        .pause (pause),
        .step  (step),
        .stop  (stop),
        .out   (out),
        .dir   (dir),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] o;
        logic       d;
        logic       b;
        logic       dn;
        logic       e;
        logic       r;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s txn=%0d got=%0d expected=%0d", tag, txn, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] o, input logic d, input logic b,
                        input logic dn, input logic e, input logic r);
        exp_t x;
        x.o = o; x.d = d; x.b = b; x.dn = dn; x.e = e; x.r = r;
        exp_q.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            x = exp_q.pop_front();
            txn++;
            $display("txn %0d out=%0d dir=%0d busy=%0d done=%0d cfg_err=%0d cfg_ready=%0d",
                     txn, out, dir, busy, done, cfg_bus.cfg_err, cfg_bus.cfg_ready);
            check_val("out", out, x.o);
            check_val("dir", {3'd0, dir}, {3'd0, x.d});
            check_val("busy", {3'd0, busy}, {3'd0, x.b});
            check_val("done", {3'd0, done}, {3'd0, x.dn});
            check_val("cfg_err", {3'd0, cfg_bus.cfg_err}, {3'd0, x.e});
            check_val("cfg_ready", {3'd0, cfg_bus.cfg_ready}, {3'd0, x.r});
        end
    endtask

    task automatic set_cfg(input logic v, input logic [3:0] lo, input logic [3:0] hi,
                           input logic [3:0] b);
        cfg_bus.cfg_valid   = v;
        cfg_bus.cfg_lo      = lo;
        cfg_bus.cfg_hi      = hi;
        cfg_bus.cfg_bounces = b;
    endtask

    initial begin
        set_cfg(1'b0, 4'd0, 4'd0, 4'd0);

        // Reset state
        #12;
        check_val("rst_out", out, 4'd0);
        check_val("rst_dir", {3'd0, dir}, 4'd0);
        check_val("rst_busy", {3'd0, busy}, 4'd0);
        check_val("rst_done", {3'd0, done}, 4'd0);
        check_val("rst_ready", {3'd0, cfg_bus.cfg_ready}, 4'd1);
        @(negedge clk);
        reset = 1'b1;

        // IDLE ignores pause, step and stop
        pause = 1'b1; push(0, 0, 0, 0, 0, 1); drain(); pause = 1'b0;
        step  = 1'b1; push(0, 0, 0, 0, 0, 1); drain(); step  = 1'b0;
        stop  = 1'b1; push(0, 0, 0, 0, 0, 1); drain(); stop  = 1'b0;
        push(0, 0, 0, 0, 0, 1); drain();

        // Default sweep; start held through RUN must be ignored
        start = 1'b1;
        for (int i = 0; i <= 15; i++) push(4'(i), 0, 1, 0, 0, 0);
        for (int i = 14; i >= 0; i--) push(4'(i), 1, 1, 0, 0, 0);
        push(1, 0, 1, 0, 0, 0);
        drain();
        start = 1'b0;
        stop = 1'b1; push(1, 0, 0, 0, 0, 1); drain(); stop = 1'b0;

        // Rejected configuration keeps the old bounds
        set_cfg(1'b1, 4'd9, 4'd9, 4'd0);
        push(1, 0, 0, 0, 1, 1); drain();
        set_cfg(1'b0, 4'd0, 4'd0, 4'd0);
        push(1, 0, 0, 0, 0, 1); drain();
        start = 1'b1; push(0, 0, 1, 0, 0, 0); drain(); start = 1'b0;
        for (int i = 1; i <= 15; i++) push(4'(i), 0, 1, 0, 0, 0);
        push(14, 1, 1, 0, 0, 0);
        drain();
        stop = 1'b1; push(14, 1, 0, 0, 0, 1); drain(); stop = 1'b0;

        // Bounded sweep lo=3 hi=6 with two reversals
        set_cfg(1'b1, 4'd3, 4'd6, 4'd2);
        push(14, 1, 0, 0, 0, 1); drain();
        set_cfg(1'b0, 4'd0, 4'd0, 4'd0);
        start = 1'b1; push(3, 0, 1, 0, 0, 0); drain(); start = 1'b0;
        push(4, 0, 1, 0, 0, 0); push(5, 0, 1, 0, 0, 0); push(6, 0, 1, 0, 0, 0);
        push(5, 1, 1, 0, 0, 0); push(4, 1, 1, 0, 0, 0); push(3, 1, 1, 0, 0, 0);
        push(3, 0, 0, 1, 0, 1); push(3, 0, 0, 0, 0, 1);
        drain();

        // Start together with a transfer uses the new bounds; pause/step/resume
        set_cfg(1'b1, 4'd2, 4'd8, 4'd0);
        start = 1'b1; push(2, 0, 1, 0, 0, 0); drain();
        start = 1'b0;
        set_cfg(1'b0, 4'd0, 4'd0, 4'd0);
        push(3, 0, 1, 0, 0, 0); push(4, 0, 1, 0, 0, 0); push(5, 0, 1, 0, 0, 0); drain();
        pause = 1'b1; push(5, 0, 1, 0, 0, 0); drain(); pause = 1'b0;
        for (int i = 0; i < 4; i++) push(5, 0, 1, 0, 0, 0);
        drain();
        step = 1'b1; push(6, 0, 1, 0, 0, 0); drain(); step = 1'b0;
        push(6, 0, 1, 0, 0, 0); drain();
        step = 1'b1; push(7, 0, 1, 0, 0, 0); drain(); step = 1'b0;
        start = 1'b1; push(7, 0, 1, 0, 0, 0); drain(); start = 1'b0;
        push(8, 0, 1, 0, 0, 0); push(7, 1, 1, 0, 0, 0); push(6, 1, 1, 0, 0, 0); drain();

        // Configuration offered during RUN is not taken; stop beats pause
        set_cfg(1'b1, 4'd0, 4'd1, 4'd3);
        push(5, 1, 1, 0, 0, 0); drain();
        set_cfg(1'b0, 4'd0, 4'd0, 4'd0);
        push(4, 1, 1, 0, 0, 0); push(3, 1, 1, 0, 0, 0); push(2, 1, 1, 0, 0, 0);
        push(3, 0, 1, 0, 0, 0);
        drain();
        stop = 1'b1; pause = 1'b1; push(3, 0, 0, 0, 0, 1); drain();
        stop = 1'b0; pause = 1'b0;
        push(3, 0, 0, 0, 0, 1); drain();

        // Asynchronous reset mid-sweep at out=11
        set_cfg(1'b1, 4'd1, 4'd13, 4'd1);
        start = 1'b1; push(1, 0, 1, 0, 0, 0); drain();
        start = 1'b0;
        set_cfg(1'b0, 4'd0, 4'd0, 4'd0);
        for (int i = 2; i <= 11; i++) push(4'(i), 0, 1, 0, 0, 0);
        drain();
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_out", out, 4'd0);
        check_val("arst_dir", {3'd0, dir}, 4'd0);
        check_val("arst_busy", {3'd0, busy}, 4'd0);
        check_val("arst_ready", {3'd0, cfg_bus.cfg_ready}, 4'd1);
        @(negedge clk);
        reset = 1'b1;
        // Bounds and limit back to 0, 15 and endless
        start = 1'b1;
        for (int i = 0; i <= 15; i++) push(4'(i), 0, 1, 0, 0, 0);
        push(14, 1, 1, 0, 0, 0);
        drain();
        start = 1'b0;
        stop = 1'b1; push(14, 1, 0, 0, 0, 1); drain(); stop = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_seq.md
COUNT_SEQ -- requirements
Module: count_seq

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (asserted at 0)
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration may be accepted
- cfg_lo  in  4  lower bound
- cfg_hi  in  4  upper bound
- cfg_bounces  in  4  direction reversals before completion; 0 = endless
- start  in  1  begin a sweep from IDLE, or resume from PAUSE
- pause  in  1  suspend a running sweep
- step  in  1  single advance while paused
- stop  in  1  abort to IDLE
- out  out  4  current count
- dir  out  1  0 = counting up, 1 = counting down
- busy  out  1  high in RUN or PAUSE
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  one-cycle rejected-configuration pulse

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, RUN, PAUSE.
REQ-004 cfg_ready SHALL be 1 exactly when the state is IDLE.
REQ-005 A configuration transfer SHALL occur on a cycle with cfg_valid=1 and cfg_ready=1.
REQ-006 On a transfer with cfg_lo < cfg_hi, the block SHALL register lo, hi and limit from the inputs.
REQ-007 On a transfer with cfg_lo >= cfg_hi, the block SHALL leave the registers unchanged and pulse cfg_err for one cycle, next cycle.
REQ-008 In IDLE, start SHALL do all of the following next cycle: out=lo, dir=0, reversal count=0, state RUN. A start that coincides with a transfer SHALL use the new values.
REQ-009 In RUN, each cycle without stop or pause SHALL advance the count once, as follows:
- dir=0, out<hi: out+1
- dir=0, out==hi: dir=1, out-1, reversal count+1
- dir=1, out>lo: out-1
- dir=1, out==lo: dir=0, out+1, reversal count+1
REQ-010 If a reversal makes the reversal count equal a nonzero limit, then instead of REQ-009:
- out SHALL hold the bound value
- dir SHALL flip
- state SHALL become IDLE
- done SHALL pulse on the next cycle
REQ-011 The reversal count SHALL be 4 bits; with limit=0 it SHALL wrap freely and never end the sweep.
REQ-012 Priority in RUN SHALL be stop > pause > advance; pause SHALL move to PAUSE with no advance that cycle.
REQ-013 Priority in PAUSE SHALL be stop > start > step:
- start returns to RUN with no advance that cycle
- step performs exactly one REQ-009/010 advance and stays in PAUSE, unless REQ-010 ends the sweep
REQ-014 stop in RUN or PAUSE SHALL go to IDLE with out and dir held, and no done pulse.
REQ-015 Inputs with no defined effect in the current state SHALL be ignored; this includes start in RUN, and pause, step and stop in IDLE.
REQ-016 out SHALL stay within [lo, hi] at all times after a start.
REQ-017 busy SHALL be registered and SHALL equal (state != IDLE).

Reset
REQ-018 While reset=0, the block SHALL force: state=IDLE, out=0, dir=0, reversal count=0, lo=0, hi=15, limit=0, done=0, cfg_err=0.
REQ-019 Reset asserted mid-sweep SHALL take effect immediately, without waiting for clk.
REQ-020 After reset releases, the block SHALL wait in IDLE for start; no count activity without start.

Verification
REQ-021 Defaults: release reset, then start -> out 0,1,...,15,14,...,0,1; dir toggles at 15 and at 0; done never asserts.
REQ-022 Config lo=3, hi=6, bounces=2, then start -> out 3,4,5,6,5,4,3 (holds 3); state IDLE; done pulses once; busy falls with done.
REQ-023 Config lo=9, hi=9 -> cfg_err pulses once; a following start sweeps 0..15, proving the old bounds were kept.
REQ-024 Sweep lo=2, hi=8; pause at out=5, hold 4 cycles -> out stays 5; step twice -> out 6, then 7; start -> counting resumes 8, 7, ...
REQ-025 Assert stop and pause together in RUN -> IDLE with out held; cfg_valid during RUN is not accepted (cfg_ready=0).
REQ-026 Drop reset asynchronously mid-sweep at out=11 -> out=0, dir=0, busy=0 before the next clk edge; bounds read back as 0 and 15.
